// File: rtl/spart_pkg.sv
// Shared SPART definitions: receive FSM states and bus register addresses.
package spart_pkg;

  // Receive FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // ioaddr decode, common to the TX, RX and baud generator stages
  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DB_LO  = 2'b10;
  localparam logic [1:0] ADDR_DB_HI  = 2'b11;

endpackage

// File: rtl/spart_sync.sv
// Multi-flop synchronizer for an asynchronous level input.
// Flops preset to 1 so an idle-high serial line never shows a false edge
// coming out of reset.
module spart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw input through the flop chain
  always_ff @(posedge clk) begin
    if (rst) chain <= '1;
    else     chain <= (chain << 1) | STAGES'(d);
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spart_rx.sv
// SPART receive stage: recovers 8N1 frames from rxd using the 16x
// oversample tick from the baud generator, holds the last byte and
// reports data-available, framing-error and overrun status to the bus.
//
// Bus handshake: a read is a single-cycle strobe (iocs & iorw) decoded by
// ioaddr; its side effects (clearing rda or the sticky errors) land on the
// next clk. A flag being set in the same cycle always wins over its clear.
//
// The FSM state is held in the internal signal `state` (rx_state_t) so
// checkers can bind to it directly.
module spart_rx
  import spart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_en,
  input  logic                 rxd,
  input  logic                 iocs,
  input  logic                 iorw,
  input  logic [1:0]           ioaddr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 framing_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  // Mid start bit is half a bit in; every later sample is a full bit later
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic rxd_s;

  rx_state_t            state, state_next;
  logic [TW-1:0]        tick_cnt, tick_next;
  logic [BW-1:0]        bit_cnt, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS:0]   shift_in;
  logic                 byte_done, frame_bad;

  logic                 data_read, status_read;
  logic [DATA_BITS-1:0] rx_data_next;
  logic                 rda_next, framing_err_next, overrun_next;

  spart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  // New sample enters at the MSB so the LSB-first byte ends up aligned
  assign shift_in = {rxd_s, shift_reg};

  // FSM state, counters and shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_next;
      tick_cnt  <= tick_next;
      bit_cnt   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  // Next-state logic: counters only move on baud_en; leaving IDLE does not wait for a tick
  always_comb begin
    state_next = state;
    tick_next  = tick_cnt;
    bit_next   = bit_cnt;
    shift_next = shift_reg;
    byte_done  = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      IDLE: begin
        if (!rxd_s) begin
          state_next = START;
          tick_next  = '0;
        end
      end
      START: begin
        if (baud_en) begin
          if (tick_cnt == TICK_MID) begin
            tick_next = '0;
            if (!rxd_s) begin
              state_next = DATA;
              bit_next   = '0;
            end else begin
              // Glitch shorter than half a bit: ignore it
              state_next = IDLE;
            end
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (baud_en) begin
          if (tick_cnt == TICK_LAST) begin
            shift_next = shift_in[DATA_BITS:1];
            tick_next  = '0;
            bit_next   = bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) state_next = STOP;
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (baud_en) begin
          if (tick_cnt == TICK_LAST) begin
            tick_next  = '0;
            state_next = IDLE;
            if (rxd_s) byte_done = 1'b1;
            else       frame_bad = 1'b1;
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus read decode; writes and divisor addresses have no effect here
  always_comb begin
    data_read   = 1'b0;
    status_read = 1'b0;
    case (ioaddr)
      ADDR_DATA:              data_read   = iocs & iorw;
      ADDR_STATUS:            status_read = iocs & iorw;
      ADDR_DB_LO, ADDR_DB_HI: ;
      default:                ;
    endcase
  end

  // Status flag update: set beats clear; overrun only if the old byte was not consumed this cycle
  always_comb begin
    rx_data_next     = rx_data;
    rda_next         = rda;
    framing_err_next = framing_err;
    overrun_next     = overrun;

    if (byte_done)      rda_next = 1'b1;
    else if (data_read) rda_next = 1'b0;

    if (byte_done) rx_data_next = shift_reg;

    if (frame_bad)        framing_err_next = 1'b1;
    else if (status_read) framing_err_next = 1'b0;

    if (byte_done && rda && !data_read) overrun_next = 1'b1;
    else if (status_read)               overrun_next = 1'b0;
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data     <= '0;
      rda         <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      rx_data     <= rx_data_next;
      rda         <= rda_next;
      framing_err <= framing_err_next;
      overrun     <= overrun_next;
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// Directed bench for spart_rx. baud_en pulses every 4th clk inside frames,
// so one bit lasts 64 clk. With the frame starting at cycle 0, the stop bit
// is sampled in cycle 607 and the registered outputs show it from cycle 608.
module tb_spart_rx;
  import spart_pkg::*;

  localparam int FRAME_CYC = 640;
  localparam int STOP_SMP  = 607;

  logic       clk;
  logic       rst;
  logic       baud_en;
  logic       rxd;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] rx_data;
  logic       rda;
  logic       framing_err;
  logic       overrun;

  int n_cmp;
  int n_err;

  logic       snap_rda_pre;
  logic       snap_rda;
  logic [7:0] snap_data;
  logic       snap_fe;
  logic       snap_ov;

  spart_rx dut (
    .clk         (clk),
    .rst         (rst),
    .baud_en     (baud_en),
    .rxd         (rxd),
    .iocs        (iocs),
    .iorw        (iorw),
    .ioaddr      (ioaddr),
    .rx_data     (rx_data),
    .rda         (rda),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Idle line, free-running baud ticks
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rxd     = 1'b1;
      iocs    = 1'b0;
      baud_en = (k % 4 == 3);
    end
  endtask

  // One-cycle bus access; outputs are sampled one clk later
  task automatic bus_op(input logic rw, input logic [1:0] addr);
    @(negedge clk);
    baud_en = 1'b0;
    iocs    = 1'b1;
    iorw    = rw;
    ioaddr  = addr;
    @(negedge clk);
    iocs    = 1'b0;
  endtask

  // Drive ncyc cycles of an 8N1 frame. A low stop bit is released early so the
  // line is idle again before the receiver's restarted start-bit sample.
  // An optional bus read lands on cycle act_at.
  task automatic send_frame(input logic [7:0] d, input logic stop_val,
                            input int act_at, input logic [1:0] act_addr,
                            input int ncyc);
    int b;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (k == STOP_SMP) snap_rda_pre = rda;
      if (k == STOP_SMP + 1) begin
        snap_rda  = rda;
        snap_data = rx_data;
        snap_fe   = framing_err;
        snap_ov   = overrun;
      end
      b = k / 64;
      if (b == 0)      rxd = 1'b0;
      else if (b <= 8) rxd = d[b-1];
      else             rxd = (k < 616) ? stop_val : 1'b1;
      baud_en = (k % 4 == 3);
      iocs    = (k == act_at);
      iorw    = 1'b1;
      ioaddr  = act_addr;
    end
    @(negedge clk);
    rxd     = 1'b1;
    iocs    = 1'b0;
    baud_en = 1'b0;
  endtask

  // Start bit shorter than half a bit
  task automatic glitch();
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      rxd     = (k < 12) ? 1'b0 : 1'b1;
      baud_en = (k % 4 == 3);
      iocs    = 1'b0;
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    baud_en = 1'b0;
    rxd     = 1'b1;
    iocs    = 1'b0;
    iorw    = 1'b0;
    ioaddr  = 2'b00;
    repeat (3) @(negedge clk);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rda", {7'd0, rda}, 8'd0);
    check("reset_fe", {7'd0, framing_err}, 8'd0);
    check("reset_ov", {7'd0, overrun}, 8'd0);
    rst = 1'b0;
    idle(16);

    // 1. good frame
    send_frame(8'hA5, 1'b1, -1, ADDR_DATA, FRAME_CYC);
    check("t1_rda_before_stop", {7'd0, snap_rda_pre}, 8'd0);
    check("t1_rda_after_stop", {7'd0, snap_rda}, 8'd1);
    check("t1_rx_data", snap_data, 8'hA5);
    check("t1_fe", {7'd0, snap_fe}, 8'd0);
    check("t1_ov", {7'd0, snap_ov}, 8'd0);
    idle(16);

    // 2. false start
    glitch();
    idle(32);
    check("t2_rda", {7'd0, rda}, 8'd1);
    check("t2_rx_data", rx_data, 8'hA5);
    check("t2_fe", {7'd0, framing_err}, 8'd0);
    check("t2_ov", {7'd0, overrun}, 8'd0);

    // Ignored accesses, then a data read
    bus_op(1'b0, ADDR_DATA);
    check("write_ignored_rda", {7'd0, rda}, 8'd1);
    bus_op(1'b1, ADDR_DB_LO);
    check("divisor_read_ignored_rda", {7'd0, rda}, 8'd1);
    bus_op(1'b1, ADDR_DATA);
    check("data_read_rda", {7'd0, rda}, 8'd0);
    check("data_read_rx_held", rx_data, 8'hA5);

    // 3. framing error, then clear by status read
    send_frame(8'h3C, 1'b0, -1, ADDR_DATA, FRAME_CYC);
    check("t3_fe", {7'd0, snap_fe}, 8'd1);
    check("t3_rda", {7'd0, snap_rda}, 8'd0);
    check("t3_rx_data_unchanged", snap_data, 8'hA5);
    idle(32);
    check("t3_restart_no_flag", {7'd0, rda}, 8'd0);
    bus_op(1'b1, ADDR_STATUS);
    check("t3_fe_cleared", {7'd0, framing_err}, 8'd0);

    // 3b. error set on the same clk as a status read
    send_frame(8'h3C, 1'b0, STOP_SMP, ADDR_STATUS, FRAME_CYC);
    check("t3b_fe_set_beats_clear", {7'd0, snap_fe}, 8'd1);
    idle(32);
    bus_op(1'b1, ADDR_STATUS);
    check("t3b_fe_cleared", {7'd0, framing_err}, 8'd0);

    // 4. overrun
    send_frame(8'h11, 1'b1, -1, ADDR_DATA, FRAME_CYC);
    check("t4_first_ov", {7'd0, snap_ov}, 8'd0);
    idle(16);
    send_frame(8'h22, 1'b1, -1, ADDR_DATA, FRAME_CYC);
    check("t4_rx_data", snap_data, 8'h22);
    check("t4_rda", {7'd0, snap_rda}, 8'd1);
    check("t4_ov", {7'd0, snap_ov}, 8'd1);
    idle(16);
    bus_op(1'b1, ADDR_DATA);
    check("t4_read_rda", {7'd0, rda}, 8'd0);
    check("t4_read_ov_kept", {7'd0, overrun}, 8'd1);
    bus_op(1'b1, ADDR_STATUS);
    check("t4_ov_cleared", {7'd0, overrun}, 8'd0);

    // 5. byte completes on the clk of a data read, with an unread byte pending
    send_frame(8'h66, 1'b1, -1, ADDR_DATA, FRAME_CYC);
    check("t5_pending_rda", {7'd0, snap_rda}, 8'd1);
    idle(16);
    send_frame(8'h77, 1'b1, STOP_SMP, ADDR_DATA, FRAME_CYC);
    check("t5_rda", {7'd0, snap_rda}, 8'd1);
    check("t5_rx_data", snap_data, 8'h77);
    check("t5_ov", {7'd0, snap_ov}, 8'd0);
    idle(16);

    // 6. reset mid-frame, then a clean frame
    send_frame(8'hFF, 1'b1, -1, ADDR_DATA, 320);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_rx_data", rx_data, 8'h00);
    check("t6_rst_rda", {7'd0, rda}, 8'd0);
    check("t6_rst_fe", {7'd0, framing_err}, 8'd0);
    check("t6_rst_ov", {7'd0, overrun}, 8'd0);
    idle(64);
    send_frame(8'h5A, 1'b1, -1, ADDR_DATA, FRAME_CYC);
    check("t6_rx_data", snap_data, 8'h5A);
    check("t6_rda", {7'd0, snap_rda}, 8'd1);
    check("t6_fe", {7'd0, snap_fe}, 8'd0);
    check("t6_ov", {7'd0, snap_ov}, 8'd0);
    idle(16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
